// File: rtl/hazard_tracking_pipe_pkg.sv
// Shared widths and Tnew/Tuse constants for the hazard tracking pipe.
// Imported by the hazard pipe and its testbench.
package hazard_tracking_pipe_pkg;

   localparam int REG_W = 5;
   localparam int T_W   = 2;

   localparam logic [T_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [T_W-1:0] TNEW_LOAD = 2'd2;
   localparam logic [T_W-1:0] TNEW_JAL  = 2'd0;

   localparam logic [T_W-1:0] TUSE_BRANCH   = 2'd0;
   localparam logic [T_W-1:0] TUSE_ALU      = 2'd1;
   localparam logic [T_W-1:0] TUSE_STORE_RT = 2'd2;

   // Decrement that clamps at zero instead of wrapping.
   function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
      tnew_dec = (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline register holding a hazard bundle (rs, rt, dest, Tnew, jal).
// Ports: clk/reset, bubble (load zeros), dec_en (store Tnew-1 clamped), *_d in, *_q out.
module hazard_stage_reg #(
   parameter int REG_W = 5,
   parameter int T_W   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bubble,
   input  logic             dec_en,
   input  logic [REG_W-1:0] ra1_d,
   input  logic [REG_W-1:0] ra2_d,
   input  logic [REG_W-1:0] wa_d,
   input  logic [T_W-1:0]   tnew_d,
   input  logic             jal_d,
   output logic [REG_W-1:0] ra1_q,
   output logic [REG_W-1:0] ra2_q,
   output logic [REG_W-1:0] wa_q,
   output logic [T_W-1:0]   tnew_q,
   output logic             jal_q
);

   logic [T_W-1:0] tnew_nx;

   // Saturating decrement: Tnew never wraps below zero.
   assign tnew_nx = !dec_en ? tnew_d
                  : (tnew_d == '0) ? '0
                  : tnew_d - 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ra1_q  <= '0;
         ra2_q  <= '0;
         wa_q   <= '0;
         tnew_q <= '0;
         jal_q  <= 1'b0;
      end else if (bubble) begin
         ra1_q  <= '0;
         ra2_q  <= '0;
         wa_q   <= '0;
         tnew_q <= '0;
         jal_q  <= 1'b0;
      end else begin
         ra1_q  <= ra1_d;
         ra2_q  <= ra2_d;
         wa_q   <= wa_d;
         tnew_q <= tnew_nx;
         jal_q  <= jal_d;
      end
   end

endmodule

// File: rtl/hazard_tracking_pipe.sv
// Tracks per-instruction hazard info from ID through EX/MEM/WB and raises stall.
// Ports: clk, reset, ID hazard fields in; per-stage regs and combinational stall out.
module hazard_tracking_pipe #(
   parameter int REG_W = hazard_tracking_pipe_pkg::REG_W,
   parameter int T_W   = hazard_tracking_pipe_pkg::T_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] RA1_ID,
   input  logic [REG_W-1:0] RA2_ID,
   input  logic [REG_W-1:0] WA_ID,
   input  logic [T_W-1:0]   Tnew_ID,
   input  logic [T_W-1:0]   Tuse_rs_ID,
   input  logic [T_W-1:0]   Tuse_rt_ID,
   input  logic             use_rs_ID,
   input  logic             use_rt_ID,
   input  logic             jal_ID,
   output logic [REG_W-1:0] RA1_EX,
   output logic [REG_W-1:0] RA2_EX,
   output logic [REG_W-1:0] RA2_MEM,
   output logic [REG_W-1:0] WA_EX,
   output logic [REG_W-1:0] WA_MEM,
   output logic [REG_W-1:0] WA_WB,
   output logic [T_W-1:0]   Tnew_EX,
   output logic [T_W-1:0]   Tnew_MEM,
   output logic [T_W-1:0]   Tnew_WB,
   output logic             jal_EX,
   output logic             jal_MEM,
   output logic             stall
);

   logic rs_hit;
   logic rt_hit;

   logic [REG_W-1:0] ra1_mem;
   logic [REG_W-1:0] ra1_wb;
   logic [REG_W-1:0] ra2_wb;
   logic             jal_wb;
   logic             unused_ok;

   // EX holds the newer producer: if it matches, it alone decides,
   // because forwarding will take the EX value over MEM.
   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      if (use_rs_ID && RA1_ID != '0) begin
         if (RA1_ID == WA_EX)
            rs_hit = Tnew_EX > Tuse_rs_ID;
         else if (RA1_ID == WA_MEM)
            rs_hit = Tnew_MEM > Tuse_rs_ID;
      end
      if (use_rt_ID && RA2_ID != '0) begin
         if (RA2_ID == WA_EX)
            rt_hit = Tnew_EX > Tuse_rt_ID;
         else if (RA2_ID == WA_MEM)
            rt_hit = Tnew_MEM > Tuse_rt_ID;
      end
   end

   assign stall = rs_hit | rt_hit;

   hazard_stage_reg #(.REG_W(REG_W), .T_W(T_W)) u_ex (
      .clk    (clk),
      .reset  (reset),
      .bubble (stall),
      .dec_en (1'b0),
      .ra1_d  (RA1_ID),
      .ra2_d  (RA2_ID),
      .wa_d   (WA_ID),
      .tnew_d (Tnew_ID),
      .jal_d  (jal_ID),
      .ra1_q  (RA1_EX),
      .ra2_q  (RA2_EX),
      .wa_q   (WA_EX),
      .tnew_q (Tnew_EX),
      .jal_q  (jal_EX)
   );

   hazard_stage_reg #(.REG_W(REG_W), .T_W(T_W)) u_mem (
      .clk    (clk),
      .reset  (reset),
      .bubble (1'b0),
      .dec_en (1'b1),
      .ra1_d  ('0),
      .ra2_d  (RA2_EX),
      .wa_d   (WA_EX),
      .tnew_d (Tnew_EX),
      .jal_d  (jal_EX),
      .ra1_q  (ra1_mem),
      .ra2_q  (RA2_MEM),
      .wa_q   (WA_MEM),
      .tnew_q (Tnew_MEM),
      .jal_q  (jal_MEM)
   );

   hazard_stage_reg #(.REG_W(REG_W), .T_W(T_W)) u_wb (
      .clk    (clk),
      .reset  (reset),
      .bubble (1'b0),
      .dec_en (1'b1),
      .ra1_d  ('0),
      .ra2_d  ('0),
      .wa_d   (WA_MEM),
      .tnew_d (Tnew_MEM),
      .jal_d  (1'b0),
      .ra1_q  (ra1_wb),
      .ra2_q  (ra2_wb),
      .wa_q   (WA_WB),
      .tnew_q (Tnew_WB),
      .jal_q  (jal_wb)
   );

   // Later stages do not carry source indices or the jal flag.
   assign unused_ok = ^{ra1_mem, ra1_wb, ra2_wb, jal_wb};

endmodule

// File: tb/tb_hazard_tracking_pipe.sv
// Directed-vector bench for hazard_tracking_pipe.
// Drives ID fields per cycle and checks stall plus all stage registers.
module tb_hazard_tracking_pipe;
   import hazard_tracking_pipe_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RA1_ID, RA2_ID, WA_ID;
   logic [1:0] Tnew_ID, Tuse_rs_ID, Tuse_rt_ID;
   logic       use_rs_ID, use_rt_ID, jal_ID;
   logic [4:0] RA1_EX, RA2_EX, RA2_MEM, WA_EX, WA_MEM, WA_WB;
   logic [1:0] Tnew_EX, Tnew_MEM, Tnew_WB;
   logic       jal_EX, jal_MEM, stall;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_tracking_pipe dut (
      .clk        (clk),
      .reset      (reset),
      .RA1_ID     (RA1_ID),
      .RA2_ID     (RA2_ID),
      .WA_ID      (WA_ID),
      .Tnew_ID    (Tnew_ID),
      .Tuse_rs_ID (Tuse_rs_ID),
      .Tuse_rt_ID (Tuse_rt_ID),
      .use_rs_ID  (use_rs_ID),
      .use_rt_ID  (use_rt_ID),
      .jal_ID     (jal_ID),
      .RA1_EX     (RA1_EX),
      .RA2_EX     (RA2_EX),
      .RA2_MEM    (RA2_MEM),
      .WA_EX      (WA_EX),
      .WA_MEM     (WA_MEM),
      .WA_WB      (WA_WB),
      .Tnew_EX    (Tnew_EX),
      .Tnew_MEM   (Tnew_MEM),
      .Tnew_WB    (Tnew_WB),
      .jal_EX     (jal_EX),
      .jal_MEM    (jal_MEM),
      .stall      (stall)
   );

   typedef struct {
      logic [4:0] ra1, ra2, wa;
      logic [1:0] tn, trs, trt;
      logic       urs, urt, jal;
      logic       stall;
      logic [4:0] ra1_ex, ra2_ex, wa_ex;
      logic [1:0] tn_ex;
      logic       jal_ex;
      logic [4:0] ra2_mem, wa_mem;
      logic [1:0] tn_mem;
      logic       jal_mem;
      logic [4:0] wa_wb;
      logic [1:0] tn_wb;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic logic [37:0] state_now();
      return {RA1_EX, RA2_EX, WA_EX, Tnew_EX, jal_EX,
              RA2_MEM, WA_MEM, Tnew_MEM, jal_MEM, WA_WB, Tnew_WB};
   endfunction

   function automatic logic [37:0] state_exp(input vec_t v);
      return {v.ra1_ex, v.ra2_ex, v.wa_ex, v.tn_ex, v.jal_ex,
              v.ra2_mem, v.wa_mem, v.tn_mem, v.jal_mem, v.wa_wb, v.tn_wb};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      RA1_ID     = v.ra1;
      RA2_ID     = v.ra2;
      WA_ID      = v.wa;
      Tnew_ID    = v.tn;
      Tuse_rs_ID = v.trs;
      Tuse_rt_ID = v.trt;
      use_rs_ID  = v.urs;
      use_rt_ID  = v.urt;
      jal_ID     = v.jal;
   endtask

   vec_t z;
   vec_t lw1;
   vec_t beq1;

   initial begin
      // lw $1 ; add $3,$1,$4 (Tuse 1) : one stall
      vecs[0]  = '{2,0,1,TNEW_LOAD,TUSE_ALU,0,1,0,0, 0, 2,0,1,2,0, 0,0,0,0, 0,0};
      vecs[1]  = '{1,4,3,TNEW_ALU,TUSE_ALU,TUSE_ALU,1,1,0, 1, 0,0,0,0,0, 0,1,1,0, 0,0};
      vecs[2]  = '{1,4,3,TNEW_ALU,TUSE_ALU,TUSE_ALU,1,1,0, 0, 1,4,3,1,0, 0,0,0,0, 1,0};
      // addu $3 in EX ; beq $3 (Tuse 0) : one stall
      vecs[3]  = '{3,0,0,0,TUSE_BRANCH,TUSE_BRANCH,1,1,0, 1, 0,0,0,0,0, 4,3,0,0, 0,0};
      vecs[4]  = '{3,0,0,0,TUSE_BRANCH,TUSE_BRANCH,1,1,0, 0, 3,0,0,0,0, 0,0,0,0, 3,0};
      // lw $5 ; beq $5,$6 : two stalls
      vecs[5]  = '{0,0,5,TNEW_LOAD,TUSE_ALU,0,1,0,0, 0, 0,0,5,2,0, 0,0,0,0, 0,0};
      vecs[6]  = '{5,6,0,0,0,0,1,1,0, 1, 0,0,0,0,0, 0,5,1,0, 0,0};
      vecs[7]  = '{5,6,0,0,0,0,1,1,0, 1, 0,0,0,0,0, 0,0,0,0, 5,0};
      vecs[8]  = '{5,6,0,0,0,0,1,1,0, 0, 5,6,0,0,0, 0,0,0,0, 0,0};
      // WA=0 producer with Tnew 2, then consumer of $0
      vecs[9]  = '{7,0,0,TNEW_LOAD,TUSE_ALU,0,1,0,0, 0, 7,0,0,2,0, 6,0,0,0, 0,0};
      vecs[10] = '{0,0,8,TNEW_ALU,0,0,1,1,0, 0, 0,0,8,1,0, 0,0,1,0, 0,0};
      // jal ; jr $31 ; nop : no stall, saturation at 0
      vecs[11] = '{0,0,31,TNEW_JAL,0,0,0,0,1, 0, 0,0,31,0,1, 0,8,0,0, 0,0};
      vecs[12] = '{31,0,0,0,TUSE_BRANCH,0,1,0,0, 0, 31,0,0,0,0, 0,31,0,1, 8,0};
      vecs[13] = '{0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0, 0,0,0,0, 31,0};
      // EX priority: EX $9 Tnew 0 masks MEM $9 Tnew 1
      vecs[14] = '{0,0,9,TNEW_LOAD,0,0,0,0,0, 0, 0,0,9,2,0, 0,0,0,0, 0,0};
      vecs[15] = '{0,0,9,0,0,0,0,0,0, 0, 0,0,9,0,0, 0,9,1,0, 0,0};
      vecs[16] = '{9,0,10,TNEW_ALU,TUSE_BRANCH,0,1,0,0, 0, 9,0,10,1,0, 0,9,0,0, 9,0};
      // rt-only hit
      vecs[17] = '{9,10,0,0,TUSE_ALU,TUSE_BRANCH,1,1,0, 1, 0,0,0,0,0, 0,10,0,0, 9,0};
      vecs[18] = '{9,10,0,0,TUSE_ALU,TUSE_BRANCH,1,1,0, 0, 9,10,0,0,0, 0,0,0,0, 10,0};
      // matching rt with use_rt=0 never stalls
      vecs[19] = '{0,0,11,TNEW_LOAD,0,0,0,0,0, 0, 0,0,11,2,0, 10,0,0,0, 0,0};
      vecs[20] = '{0,11,0,0,0,0,0,0,0, 0, 0,11,0,0,0, 0,11,1,0, 0,0};

      z    = '{0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0, 0,0,0,0, 0,0};
      lw1  = z;
      lw1.ra1 = 2; lw1.wa = 1; lw1.tn = TNEW_LOAD;
      beq1 = z;
      beq1.ra1 = 1; beq1.urs = 1; beq1.trs = TUSE_BRANCH;

      reset = 1'b1;
      drive(z);
      #7;
      chk("reset_state", 64'(state_now()), 64'(38'd0));
      chk("reset_stall", 64'(stall), 64'(1'b0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #2;
         chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].stall));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_regs", i), 64'(state_now()),
             64'(state_exp(vecs[i])));
      end

      // Reset asserted mid-stall with lw in MEM and beq waiting in ID.
      @(negedge clk);
      drive(lw1);
      @(negedge clk);
      drive(beq1);
      #2;
      chk("mid_stall_ex", 64'(stall), 64'(1'b1));
      @(negedge clk);
      #2;
      chk("mid_stall_mem", 64'(stall), 64'(1'b1));
      chk("mid_tnew_mem", 64'(Tnew_MEM), 64'(2'd1));
      reset = 1'b1;
      #1;
      chk("async_rst_regs", 64'(state_now()), 64'(38'd0));
      chk("async_rst_stall", 64'(stall), 64'(1'b0));
      @(posedge clk);
      #1;
      chk("held_rst_regs", 64'(state_now()), 64'(38'd0));
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("post_rst_stall", 64'(stall), 64'(1'b0));
      @(posedge clk);
      #1;
      chk("post_rst_issue", 64'({RA1_EX, WA_EX, Tnew_EX}),
          64'({5'd1, 5'd0, 2'd0}));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
